// File: rtl/wb_regfile_scoreboard.sv
// Write-back stage register files (scalar + vector) with registered read ports and a
// per-register in-flight scoreboard that stalls decode on RAW hazards. Optional macro: WB_BYPASS_EN.
module wb_regfile_scoreboard #(
  parameter int NREG = 16,
  parameter int DW   = 32,
  parameter int CNTW = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wb_sel_dat,
  input  logic          i_wb_sel_c,
  input  logic          i_wb_we_c,
  input  logic          i_wb_we_v,
  input  logic          i_wb_prohib,
  input  logic [DW-1:0] i_wb_do,
  input  logic [7:0]    i_wb_dob,
  input  logic [DW-1:0] i_wb_alu_result,
  input  logic [AW-1:0] i_wb_rg,
  input  logic          i_iss_valid,
  input  logic          i_iss_wr,
  input  logic [AW-1:0] i_iss_rd,
  input  logic          i_iss_rd_vec,
  input  logic          i_ra_en,
  input  logic          i_rb_en,
  input  logic [AW-1:0] i_ra_addr,
  input  logic [AW-1:0] i_rb_addr,
  input  logic          i_ra_vec,
  input  logic          i_rb_vec,
  output logic [DW-1:0] o_ra_data,
  output logic [DW-1:0] o_rb_data,
  output logic          o_stall
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [DW-1:0]   r_scalar [NREG];
  logic [DW-1:0]   r_vector [NREG];
  logic [CNTW-1:0] r_cnt_c  [NREG];
  logic [CNTW-1:0] r_cnt_v  [NREG];
  logic [DW-1:0]   r_ra_data;
  logic [DW-1:0]   r_rb_data;

  logic [DW-1:0]   w_wdata;
  logic            w_ret_c;
  logic            w_ret_v;
  logic            w_wr_c;
  logic            w_wr_v;
  logic            w_issue;
  logic [NREG-1:0] w_inc_c;
  logic [NREG-1:0] w_inc_v;
  logic [NREG-1:0] w_dec_c;
  logic [NREG-1:0] w_dec_v;
  logic [CNTW-1:0] w_cnt_a;
  logic [CNTW-1:0] w_cnt_b;
  logic [CNTW-1:0] w_cnt_rd;
  logic            w_ret_rd;
  logic            w_hz_a;
  logic            w_hz_b;
  logic            w_rd_full;
  logic [DW-1:0]   w_ra_next;
  logic [DW-1:0]   w_rb_next;

  always_comb begin
    w_wdata = i_wb_alu_result;
    if (i_wb_sel_dat) begin
      w_wdata = i_wb_sel_c ? {{(DW-8){1'b0}}, i_wb_dob} : i_wb_do;
    end
  end

  // Scalar R0 is hardwired: it is never retired, written or counted.
  assign w_ret_c = i_wb_we_c && (i_wb_rg != '0);
  assign w_ret_v = i_wb_we_v;
  assign w_wr_c  = w_ret_c && !i_wb_prohib;
  assign w_wr_v  = w_ret_v && !i_wb_prohib;

  assign w_cnt_a  = i_ra_vec ? r_cnt_v[i_ra_addr] : r_cnt_c[i_ra_addr];
  assign w_cnt_b  = i_rb_vec ? r_cnt_v[i_rb_addr] : r_cnt_c[i_rb_addr];
  assign w_cnt_rd = i_iss_rd_vec ? r_cnt_v[i_iss_rd] : r_cnt_c[i_iss_rd];
  assign w_ret_rd = i_iss_rd_vec ? (w_ret_v && (i_wb_rg == i_iss_rd))
                                 : (w_ret_c && (i_wb_rg == i_iss_rd));

`ifdef WB_BYPASS_EN
  logic w_wr_a;
  logic w_wr_b;

  assign w_wr_a = i_ra_vec ? (w_wr_v && (i_wb_rg == i_ra_addr))
                           : (w_wr_c && (i_wb_rg == i_ra_addr));
  assign w_wr_b = i_rb_vec ? (w_wr_v && (i_wb_rg == i_rb_addr))
                           : (w_wr_c && (i_wb_rg == i_rb_addr));

  // A last outstanding write landing this cycle is forwarded, so it no longer blocks the reader.
  assign w_hz_a = i_ra_en && (w_cnt_a != '0) && !((w_cnt_a == CNT_ONE) && w_wr_a);
  assign w_hz_b = i_rb_en && (w_cnt_b != '0) && !((w_cnt_b == CNT_ONE) && w_wr_b);
`else
  assign w_hz_a = i_ra_en && (w_cnt_a != '0);
  assign w_hz_b = i_rb_en && (w_cnt_b != '0);
`endif

  assign w_rd_full = i_iss_wr && (w_cnt_rd == CNT_MAX) && !w_ret_rd;
  assign o_stall   = i_iss_valid && (w_hz_a || w_hz_b || w_rd_full);
  assign w_issue   = i_iss_valid && i_iss_wr && !o_stall;

  always_comb begin
    w_inc_c = '0;
    w_inc_v = '0;
    w_dec_c = '0;
    w_dec_v = '0;
    if (w_issue && i_iss_rd_vec) begin
      w_inc_v[i_iss_rd] = 1'b1;
    end
    if (w_issue && !i_iss_rd_vec && (i_iss_rd != '0)) begin
      w_inc_c[i_iss_rd] = 1'b1;
    end
    if (w_ret_c) begin
      w_dec_c[i_wb_rg] = 1'b1;
    end
    if (w_ret_v) begin
      w_dec_v[i_wb_rg] = 1'b1;
    end
  end

  // Simultaneous issue and retire cancel; a retire with nothing outstanding saturates at zero.
  function automatic logic [CNTW-1:0] nextCount(input logic [CNTW-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNTW-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + CNT_ONE;
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - CNT_ONE;
    end
    return res;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt_c[i] <= '0;
        r_cnt_v[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt_c[i] <= nextCount(r_cnt_c[i], w_inc_c[i], w_dec_c[i]);
        r_cnt_v[i] <= nextCount(r_cnt_v[i], w_inc_v[i], w_dec_v[i]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_scalar[i] <= '0;
        r_vector[i] <= '0;
      end
    end else begin
      if (w_wr_c) begin
        r_scalar[i_wb_rg] <= w_wdata;
      end
      if (w_wr_v) begin
        r_vector[i_wb_rg] <= w_wdata;
      end
    end
  end

  always_comb begin
    w_ra_next = i_ra_vec ? r_vector[i_ra_addr] : r_scalar[i_ra_addr];
    w_rb_next = i_rb_vec ? r_vector[i_rb_addr] : r_scalar[i_rb_addr];
    if (!i_ra_vec && (i_ra_addr == '0)) begin
      w_ra_next = '0;
    end
    if (!i_rb_vec && (i_rb_addr == '0)) begin
      w_rb_next = '0;
    end
`ifdef WB_BYPASS_EN
    if (w_wr_a) begin
      w_ra_next = w_wdata;
    end
    if (w_wr_b) begin
      w_rb_next = w_wdata;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ra_data <= '0;
      r_rb_data <= '0;
    end else begin
      r_ra_data <= w_ra_next;
      r_rb_data <= w_rb_next;
    end
  end

  assign o_ra_data = r_ra_data;
  assign o_rb_data = r_rb_data;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Self-checking bench for wb_regfile_scoreboard: directed scenarios then random traffic,
// compared against an array-based model of the register files and in-flight counts.
module tb_wb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbSelDat, wbSelC, wbWeC, wbWeV, wbProhib;
  logic [31:0] wbDo, wbAlu;
  logic [7:0]  wbDob;
  logic [3:0]  wbRg;
  logic        issValid, issWr, issRdVec;
  logic [3:0]  issRd;
  logic        raEn, rbEn, raVec, rbVec;
  logic [3:0]  raAddr, rbAddr;
  logic [31:0] raData, rbData;
  logic        stall;

  int errors = 0;
  int checks = 0;

  logic [31:0] regC [16];
  logic [31:0] regV [16];
  int          cntC [16];
  int          cntV [16];

  wb_regfile_scoreboard dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_sel_dat(wbSelDat), .i_wb_sel_c(wbSelC), .i_wb_we_c(wbWeC), .i_wb_we_v(wbWeV),
    .i_wb_prohib(wbProhib), .i_wb_do(wbDo), .i_wb_dob(wbDob), .i_wb_alu_result(wbAlu),
    .i_wb_rg(wbRg), .i_iss_valid(issValid), .i_iss_wr(issWr), .i_iss_rd(issRd),
    .i_iss_rd_vec(issRdVec), .i_ra_en(raEn), .i_rb_en(rbEn), .i_ra_addr(raAddr),
    .i_rb_addr(rbAddr), .i_ra_vec(raVec), .i_rb_vec(rbVec),
    .o_ra_data(raData), .o_rb_data(rbData), .o_stall(stall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelWdata();
    if (!wbSelDat) return wbAlu;
    return wbSelC ? {24'b0, wbDob} : wbDo;
  endfunction

  function automatic int countOf(input logic vec, input logic [3:0] a);
    return vec ? cntV[a] : cntC[a];
  endfunction

  function automatic logic retiring(input logic vec, input logic [3:0] a);
    if (vec) return wbWeV && (wbRg == a);
    return wbWeC && (wbRg == a) && (a != 4'd0);
  endfunction

  function automatic logic writing(input logic vec, input logic [3:0] a);
    return retiring(vec, a) && !wbProhib;
  endfunction

  function automatic logic hazard(input logic en, input logic vec, input logic [3:0] a);
    if (!en || countOf(vec, a) == 0) return 1'b0;
`ifdef WB_BYPASS_EN
    if (countOf(vec, a) == 1 && writing(vec, a)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] readVal(input logic vec, input logic [3:0] a);
    if (!vec && a == 4'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (writing(vec, a)) return modelWdata();
`endif
    return vec ? regV[a] : regC[a];
  endfunction

  task automatic idle();
    wbSelDat = 0; wbSelC = 0; wbWeC = 0; wbWeV = 0; wbProhib = 0;
    wbDo = 0; wbDob = 0; wbAlu = 0; wbRg = 0;
    issValid = 0; issWr = 0; issRd = 0; issRdVec = 0;
    raEn = 0; rbEn = 0; raVec = 0; rbVec = 0; raAddr = 0; rbAddr = 0;
  endtask

  // One clock: check stall before the edge, update the model at the edge, check reads after it.
  task automatic applyStimulus(input string tag);
    logic        expStall, issue;
    logic [31:0] expRa, expRb, wd;
    #1;
    expStall = issValid && (hazard(raEn, raVec, raAddr) || hazard(rbEn, rbVec, rbAddr) ||
               (issWr && countOf(issRdVec, issRd) == 3 && !retiring(issRdVec, issRd)));
    checkOutput({tag, ".stall"}, {31'b0, stall}, {31'b0, expStall});
    expRa = rst ? 32'd0 : readVal(raVec, raAddr);
    expRb = rst ? 32'd0 : readVal(rbVec, rbAddr);
    wd = modelWdata();
    issue = issValid && issWr && !expStall;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regC[i] = 0; regV[i] = 0; cntC[i] = 0; cntV[i] = 0;
      end
    end else begin
      for (int i = 1; i < 16; i++) begin
        if ((issue && !issRdVec && issRd == i) && !retiring(1'b0, 4'(i))) cntC[i]++;
        else if (!(issue && !issRdVec && issRd == i) && retiring(1'b0, 4'(i)) && cntC[i] > 0) cntC[i]--;
      end
      for (int i = 0; i < 16; i++) begin
        if ((issue && issRdVec && issRd == i) && !retiring(1'b1, 4'(i))) cntV[i]++;
        else if (!(issue && issRdVec && issRd == i) && retiring(1'b1, 4'(i)) && cntV[i] > 0) cntV[i]--;
      end
      if (!wbProhib && wbWeC && wbRg != 0) regC[wbRg] = wd;
      if (!wbProhib && wbWeV) regV[wbRg] = wd;
    end
    #1;
    checkOutput({tag, ".ra"}, raData, expRa);
    checkOutput({tag, ".rb"}, rbData, expRb);
  endtask

  initial begin
    idle();
    rst = 1;
    applyStimulus("reset0");
    applyStimulus("reset1");
    rst = 0;

    raAddr = 5; rbAddr = 5; rbVec = 1;
    applyStimulus("readR5V5");
    checkOutput("resetR5", raData, 32'd0);

    idle(); wbAlu = 32'hDEADBEEF; wbWeC = 1; wbRg = 3;
    applyStimulus("wbR3");
    idle(); raAddr = 3;
    applyStimulus("readR3");
    checkOutput("R3value", raData, 32'hDEADBEEF);

    idle(); wbSelDat = 1; wbSelC = 1; wbDob = 8'hA5; wbDo = 32'h12345678; wbWeV = 1; wbRg = 7;
    applyStimulus("wbV7byte");
    idle(); raVec = 1; raAddr = 7;
    applyStimulus("readV7byte");
    checkOutput("V7byte", raData, 32'h000000A5);
    idle(); wbSelDat = 1; wbDob = 8'hA5; wbDo = 32'h12345678; wbWeV = 1; wbRg = 7;
    applyStimulus("wbV7word");
    idle(); raVec = 1; raAddr = 7;
    applyStimulus("readV7word");
    checkOutput("V7word", raData, 32'h12345678);
    idle(); wbAlu = 32'hFFFFFFFF; wbWeV = 1; wbRg = 7; wbProhib = 1;
    applyStimulus("wbV7prohib");
    idle(); raVec = 1; raAddr = 7;
    applyStimulus("readV7prohib");
    checkOutput("V7kept", raData, 32'h12345678);

    idle(); issValid = 1; issWr = 1; issRd = 4;
    applyStimulus("issueR4");
    idle(); issValid = 1; issWr = 1; issRd = 9; raEn = 1; raAddr = 4;
    applyStimulus("depR4a");
    applyStimulus("depR4b");
    wbWeC = 1; wbRg = 4; wbAlu = 32'h44440004;
    applyStimulus("depR4retire");
    wbWeC = 0;
    applyStimulus("depR4after");
    idle(); wbWeC = 1; wbRg = 9;
    applyStimulus("retireR9");

    idle(); issValid = 1; issWr = 1; issRd = 2;
    for (int i = 0; i < 3; i++) applyStimulus("issueR2");
    applyStimulus("fullR2");
    wbWeC = 1; wbRg = 2; wbAlu = 32'h22222222;
    applyStimulus("fullR2retire");
    idle(); wbWeC = 1; wbRg = 2;
    for (int i = 0; i < 3; i++) applyStimulus("drainR2");

    idle(); issValid = 1; issWr = 1; issRd = 1;
    applyStimulus("issueR1");
    idle(); wbWeC = 1; wbRg = 1; wbProhib = 1; wbAlu = 32'h11111111;
    applyStimulus("prohibR1");
    idle(); issValid = 1; raEn = 1; raAddr = 1;
    applyStimulus("depR1");
    idle(); issValid = 1; issWr = 1; issRd = 0; raEn = 1; raAddr = 0;
    for (int i = 0; i < 5; i++) applyStimulus("issueR0");

    idle(); issValid = 1; issWr = 1; issRd = 6; issRdVec = 1;
    applyStimulus("issueV6");
    rst = 1; wbWeV = 1; wbRg = 6; wbAlu = 32'h66666666;
    applyStimulus("midReset");
    rst = 0; idle(); issValid = 1; raEn = 1; raVec = 1; raAddr = 6; rbVec = 1; rbAddr = 6;
    applyStimulus("afterReset");

    for (int n = 0; n < 400; n++) begin
      idle();
      wbWeC = ($urandom_range(0, 2) == 0);
      wbWeV = ($urandom_range(0, 3) == 0);
      wbRg = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wbSelDat = 1'($urandom); wbSelC = 1'($urandom);
      wbProhib = ($urandom_range(0, 4) == 0);
      wbDo = $urandom; wbDob = 8'($urandom); wbAlu = $urandom;
      issValid = 1'($urandom); issWr = ($urandom_range(0, 3) != 0);
      issRd = 4'($urandom_range(0, 3)); issRdVec = 1'($urandom);
      raEn = 1'($urandom); rbEn = 1'($urandom);
      raVec = 1'($urandom); rbVec = 1'($urandom);
      raAddr = 4'($urandom_range(0, 4)); rbAddr = 4'($urandom_range(0, 15));
      applyStimulus("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
